// File: rtl/mont_mul_if.sv
// Bus between a Montgomery-multiply requester and mont_mul_ws.
// Purpose : groups the start/operand inputs and the busy/done/result outputs
//           so that the two sides connect through a single port.
// Signals : start    1-cycle request, honoured only while the core is idle
//           A, B     operands, both must be < N
//           N        odd modulus
//           n0prime  -N^-1 mod 2^W, supplied by the upstream n0prime stage
//           busy     high while an operation is in progress
//           done     single-cycle completion pulse
//           result   A*B*2^(-W*S) mod N, held until the next accepted start
// Modports: master drives the request side; slave is the multiplier.
interface mont_mul_if #(
    parameter int W = 32,
    parameter int S = 32
) ();
    localparam int N_BITS = W * S;

    logic              start;
    logic [N_BITS-1:0] A;
    logic [N_BITS-1:0] B;
    logic [N_BITS-1:0] N;
    logic [W-1:0]      n0prime;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] result;

    modport master (
        output start, A, B, N, n0prime,
        input  busy, done, result
    );

    modport slave (
        input  start, A, B, N, n0prime,
        output busy, done, result
    );
endinterface

// File: rtl/mont_mul_ws.sv
// Word-serial Montgomery multiplier: result = A*B*2^(-W*S) mod N.
// Purpose : one W-bit word of A is folded into the accumulator per ACC/RED
//           pair, so an operation takes 2*S+1 cycles from the accepted start
//           to the done pulse.
// Ports   : clk    rising-edge clock
//           reset  synchronous, active-high
//           bus    mont_mul_if slave modport (start, A, B, N, n0prime in;
//                  busy, done, result out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands are latched on the accepting edge
// ACC   | T += a_word * B, a_word being the current low word of A
// RED   | T = (T + m*N) >> W with m chosen so the low word cancels
// FIN   | final conditional subtract into result, pulse done
module mont_mul_ws #(
    parameter int W = 32,
    parameter int S = 32
) (
    input  logic       clk,
    input  logic       reset,
    mont_mul_if.slave  bus
);
    localparam int N_BITS = W * S;
    localparam int TW     = N_BITS + W + 1;
    // One spare bit over T: T + m*N can reach 2^(W+1)*N before the shift.
    localparam int SW     = TW + 1;
    localparam int IW     = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RED  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic [N_BITS-1:0] n_q, n_d;
    logic [W-1:0]      n0_q, n0_d;
    logic [TW-1:0]     t_q, t_d;
    logic [IW-1:0]     i_q, i_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [W-1:0]      m;
    logic [TW-1:0]     t_acc;
    logic [SW-1:0]     red_sum;
    logic [TW-1:0]     n_ext;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        n0_d     = n0_q;
        t_d      = t_q;
        i_d      = i_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // a_q is consumed as a shift register, so the current word is always
        // its low W bits.
        t_acc   = t_q + TW'(a_q[W-1:0]) * TW'(b_q);
        m       = t_q[W-1:0] * n0_q;
        red_sum = SW'(t_q) + SW'(m) * SW'(n_q);
        n_ext   = TW'(n_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    n_d     = bus.N;
                    n0_d    = bus.n0prime;
                    t_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                t_d     = t_acc;
                state_d = RED;
            end
            RED: begin
                // Low W bits of red_sum are zero by choice of m.
                t_d = TW'(red_sum >> W);
                a_d = a_q >> W;
                if (i_q == IW'(S - 1)) begin
                    state_d = FIN;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = ACC;
                end
            end
            FIN: begin
                result_d = (t_q >= n_ext) ? N_BITS'(t_q - n_ext) : N_BITS'(t_q);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            n0_q     <= '0;
            t_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            n0_q     <= n0_d;
            t_q      <= t_d;
            i_q      <= i_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mont_mul_ws.sv
// Bench for mont_mul_ws: a small W=4/S=2 instance for directed and exhaustive
// cases and a default W=32/S=32 instance for random 1024-bit operands.
// Expected results are queued when a request is issued; per-instance monitors
// pop and compare whenever done is seen, also checking latency.
module tb_mont_mul_ws;
    localparam int WS = 4;
    localparam int SS = 2;
    localparam int NS = WS * SS;
    localparam int WL = 32;
    localparam int SL = 32;
    localparam int NL = WL * SL;

    typedef logic [1039:0] big_t;
    typedef struct {
        big_t res;
        int   e0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s;
    logic rst_l;

    mont_mul_if #(.W(WS), .S(SS)) if_s ();
    mont_mul_if #(.W(WL), .S(SL)) if_l ();

    mont_mul_ws #(.W(WS), .S(SS)) dut_s (.clk(clk), .reset(rst_s), .bus(if_s));
    mont_mul_ws #(.W(WL), .S(SL)) dut_l (.clk(clk), .reset(rst_l), .bus(if_l));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    exp_t q_s[$];
    exp_t q_l[$];
    logic done_prev_s = 1'b0;
    logic done_prev_l = 1'b0;

    task automatic chk(input string name, input big_t act, input big_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // A*B*2^(-nbits) mod n: modular product by double-and-add, then
    // nbits modular halvings (n odd, so x+n is even whenever x is odd).
    function automatic big_t ref_mont(input big_t a, input big_t b, input big_t n, input int nbits);
        big_t x;
        x = '0;
        for (int k = nbits - 1; k >= 0; k--) begin
            x = x << 1;
            if (x >= n) x = x - n;
            if (b[k]) begin
                x = x + a;
                if (x >= n) x = x - n;
            end
        end
        for (int k = 0; k < nbits; k++) begin
            if (x[0]) x = x + n;
            x = x >> 1;
        end
        return x;
    endfunction

    // Upstream n0prime stage: Newton iteration for N^-1 mod 2^32, negated.
    function automatic logic [31:0] n0p(input big_t n, input int w);
        logic [31:0] n32;
        logic [31:0] x;
        logic [31:0] mask;
        n32 = n[31:0];
        x   = n32;
        for (int k = 0; k < 5; k++) x = x * (32'd2 - n32 * x);
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (32'd0 - x) & mask;
    endfunction

    function automatic big_t rnd_big(input int nbits);
        big_t x;
        big_t one;
        x   = '0;
        one = 1;
        for (int k = 0; k < 33; k++) x = (x << 32) | big_t'($urandom);
        return x & ((one << nbits) - one);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (if_s.done) begin
            if (done_prev_s) begin
                total++; bad++;
                $display("FAIL s_done_twice: actual=two consecutive done required=single pulse");
            end
            if (q_s.size() == 0) begin
                total++; bad++;
                $display("FAIL s_unexpected_done: actual=done required=no done");
            end else begin
                e = q_s.pop_front();
                chk("s_result", big_t'(if_s.result), e.res);
                chk("s_latency", big_t'(cyc - e.e0), big_t'(2 * SS + 1));
                chk("s_busy_at_done", big_t'(if_s.busy), 0);
            end
        end
        done_prev_s = if_s.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_l.done) begin
            if (done_prev_l) begin
                total++; bad++;
                $display("FAIL l_done_twice: actual=two consecutive done required=single pulse");
            end
            if (q_l.size() == 0) begin
                total++; bad++;
                $display("FAIL l_unexpected_done: actual=done required=no done");
            end else begin
                e = q_l.pop_front();
                chk("l_result", big_t'(if_l.result), e.res);
                chk("l_latency", big_t'(cyc - e.e0), big_t'(2 * SL + 1));
            end
        end
        done_prev_l = if_l.done;
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue_s(input big_t a, input big_t b, input big_t n, input big_t expv);
        logic [31:0] n0;
        n0 = n0p(n, WS);
        if_s.start   = 1'b1;
        if_s.A       = a[NS-1:0];
        if_s.B       = b[NS-1:0];
        if_s.N       = n[NS-1:0];
        if_s.n0prime = n0[WS-1:0];
        q_s.push_back('{res: expv, e0: cyc + 1});
        @(negedge clk);
        if_s.start   = 1'b0;
        if_s.A       = ~if_s.A;
        if_s.B       = ~if_s.B;
        if_s.N       = ~if_s.N;
        if_s.n0prime = ~if_s.n0prime;
        chk("s_busy_after_start", big_t'(if_s.busy), 1);
    endtask

    task automatic issue_l(input big_t a, input big_t b, input big_t n, input big_t expv);
        logic [31:0] n0;
        n0 = n0p(n, WL);
        if_l.start   = 1'b1;
        if_l.A       = a[NL-1:0];
        if_l.B       = b[NL-1:0];
        if_l.N       = n[NL-1:0];
        if_l.n0prime = n0;
        q_l.push_back('{res: expv, e0: cyc + 1});
        @(negedge clk);
        if_l.start   = 1'b0;
        if_l.A       = ~if_l.A;
        if_l.B       = ~if_l.B;
        if_l.N       = ~if_l.N;
        if_l.n0prime = ~if_l.n0prime;
    endtask

    // Leaves the caller on the done negedge (advance=0) or the one after.
    task automatic wait_done_s(input int budget, input bit advance);
        int k;
        k = 0;
        while (!if_s.done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!if_s.done) begin
            total++; bad++;
            $display("FAIL s_timeout: actual=no done required=done within %0d cycles", budget);
        end
        if (advance) @(negedge clk);
    endtask

    task automatic wait_done_l(input int budget);
        int k;
        k = 0;
        while (!if_l.done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!if_l.done) begin
            total++; bad++;
            $display("FAIL l_timeout: actual=no done required=done within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        big_t a, b, n, r1, r2;
        int   k;

        rst_s = 1'b1;
        rst_l = 1'b1;
        if_s.start = 1'b0; if_s.A = '0; if_s.B = '0; if_s.N = '0; if_s.n0prime = '0;
        if_l.start = 1'b0; if_l.A = '0; if_l.B = '0; if_l.N = '0; if_l.n0prime = '0;
        repeat (3) @(negedge clk);
        chk("s_reset_busy",   big_t'(if_s.busy), 0);
        chk("s_reset_done",   big_t'(if_s.done), 0);
        chk("s_reset_result", big_t'(if_s.result), 0);
        chk("l_reset_busy",   big_t'(if_l.busy), 0);
        chk("l_reset_result", big_t'(if_l.result), 0);
        rst_s = 1'b0;
        rst_l = 1'b0;
        @(negedge clk);

        // Directed small-config cases, N=13, R=256.
        issue_s(1, 1, 13, 3);    wait_done_s(20, 1);
        issue_s(9, 9, 13, 9);    wait_done_s(20, 1);
        issue_s(12, 12, 13, 3);  wait_done_s(20, 1);
        issue_s(0, 12, 13, 0);   wait_done_s(20, 1);

        // Every operand pair for N=13 (covers the final-subtract branch).
        for (int x = 0; x < 13; x++) begin
            for (int y = 0; y < 13; y++) begin
                issue_s(x, y, 13, ref_mont(x, y, 13, NS));
                wait_done_s(20, 1);
            end
        end

        // Random odd 8-bit moduli.
        for (int t = 0; t < 60; t++) begin
            n = big_t'($urandom_range(1, 127) * 2 + 1);
            a = big_t'($urandom % n[31:0]);
            b = big_t'($urandom % n[31:0]);
            issue_s(a, b, n, ref_mont(a, b, n, NS));
            wait_done_s(20, 1);
        end

        // Start re-pulsed at cycles 1 and 3 of an operation is ignored.
        issue_s(7, 11, 13, ref_mont(7, 11, 13, NS));
        if_s.start = 1'b1; if_s.A = 8'd2; if_s.B = 8'd3; if_s.N = 8'd13;
        @(negedge clk);
        if_s.start = 1'b0;
        @(negedge clk);
        if_s.start = 1'b1; if_s.A = 8'd5;
        @(negedge clk);
        if_s.start = 1'b0;
        wait_done_s(20, 1);
        repeat (10) @(negedge clk);

        // Reset at cycle 3 aborts with no done; result had been nonzero.
        issue_s(4, 6, 13, ref_mont(4, 6, 13, NS));
        repeat (2) @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        chk("s_abort_busy",   big_t'(if_s.busy), 0);
        chk("s_abort_done",   big_t'(if_s.done), 0);
        chk("s_abort_result", big_t'(if_s.result), 0);
        rst_s = 1'b0;
        q_s.delete();
        repeat (12) @(negedge clk);
        issue_s(4, 6, 13, ref_mont(4, 6, 13, NS));
        wait_done_s(20, 1);

        // Back-to-back: second start in the done cycle of the first.
        r1 = ref_mont(10, 5, 13, NS);
        r2 = ref_mont(8, 12, 13, NS);
        issue_s(10, 5, 13, r1);
        wait_done_s(20, 0);
        issue_s(8, 12, 13, r2);
        chk("s_b2b_done_cleared", big_t'(if_s.done), 0);
        k = 0;
        while (!if_s.done && k < 20) begin
            chk("s_hold_first_result", big_t'(if_s.result), r1);
            @(negedge clk);
            k++;
        end
        wait_done_s(20, 1);

        // Default config: 200 random 1024-bit odd moduli.
        for (int t = 0; t < 200; t++) begin
            big_t one;
            one = 1;
            n = rnd_big(NL) | (one << (NL - 1)) | one;
            a = rnd_big(NL);
            b = rnd_big(NL);
            if (a >= n) a = a - n;
            if (b >= n) b = b - n;
            issue_l(a, b, n, ref_mont(a, b, n, NL));
            wait_done_l(100);
        end

        repeat (5) @(negedge clk);
        chk("s_queue_drained", big_t'(q_s.size()), 0);
        chk("l_queue_drained", big_t'(q_l.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
